// File: rtl/evt_tx_pkg.sv
// Shared definitions for the event transmit path: event codes, record layout, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package evt_tx_pkg;

   localparam logic [1:0] EVT_NONE   = 2'b00;
   localparam logic [5:0] MARKER_UID = 6'h3F;

   // 16-bit record: {code[15:14], uid[13:8], row[7:0]}, high byte sent first
   localparam int REC_CODE_LSB = 14;
   localparam int REC_UID_LSB  = 8;
   localparam int REC_ROW_LSB  = 0;
   localparam int UID_W        = 6;
   localparam int ROW_W        = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      SEND_HI = 2'd2,
      SEND_LO = 2'd3
   } tx_state_t;

   function automatic logic [15:0] make_record(input logic [1:0]       code,
                                               input logic [UID_W-1:0] uid,
                                               input logic [ROW_W-1:0] row);
      logic [15:0] rec;
      rec = '0;
      rec[REC_CODE_LSB +: 2]     = code;
      rec[REC_UID_LSB  +: UID_W] = uid;
      rec[REC_ROW_LSB  +: ROW_W] = row;
      return rec;
   endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// Generic synchronous FIFO with full/empty flags, 2^AW entries.
// Latency: a pushed word is visible on pop_data the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; caller gates on flags.
module evt_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; reset discards all stored entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage write; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/event_tx_packer.sv
// Buffers nonzero event rows and serialises each unit event as a 2-byte record (optional EVT_TX_FRAME_MARKER_EN adds frame markers).
// Latency: first byte 3 cycles after the row push when unit 0 has an event; each zero unit adds one cycle.
// Backpressure: tx_valid/tx_data hold until tx_ready; a full row FIFO drops the new entry and counts it.
module event_tx_packer #(
   parameter int NUM_UNITS  = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int FIFO_AW    = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2*NUM_UNITS-1:0] event_in_array,
   input  logic                   event_in_valid,
   input  logic                   frame_start,
   input  logic                   frame_end,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   overflow,
   output logic [7:0]             drop_count,
   output logic                   busy
);

   import evt_tx_pkg::*;

   localparam int EV_W  = 2 * NUM_UNITS;
   localparam int ENT_W = 1 + ROW_W + EV_W;
   localparam logic [UID_W-1:0] LAST_UID = UID_W'(NUM_UNITS - 1);

   logic [ADDR_WIDTH-1:0] row_cnt;
   logic                  row_push;
   logic                  push_req;
   logic [ENT_W-1:0]      push_entry;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [ENT_W-1:0]      fifo_rd;
   logic                  fifo_full;
   logic                  fifo_empty;

   tx_state_t             state_q, state_d;
   logic [UID_W-1:0]      uid_q, uid_d;
   logic [ENT_W-1:0]      work_q, work_d;

   logic                  work_marker;
   logic [ROW_W-1:0]      work_row;
   logic [EV_W-1:0]       work_ev;
   logic [EV_W-1:0]       ev_shift;
   logic [1:0]            cur_code;
   logic [15:0]           rec;

   // Row index of the current sweep row; frame_start wins over increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_cnt <= '0;
      end else if (frame_start) begin
         row_cnt <= '0;
      end else if (event_in_valid) begin
         row_cnt <= row_cnt + 1'b1;
      end
   end

   assign row_push = event_in_valid && (event_in_array != '0);

`ifdef EVT_TX_FRAME_MARKER_EN
   logic [7:0] frame_cnt;
   logic       marker_pend;
   logic       marker_req;

   // A marker only goes in on a cycle without a row push, so rows seen before frame_end stay ahead of it
   assign marker_req = (frame_end || marker_pend) && !row_push;
   assign push_req   = row_push || marker_req;
   assign push_entry = row_push ? {1'b0, ROW_W'(row_cnt), event_in_array}
                                : {1'b1, frame_cnt, {EV_W{1'b0}}};

   // Frame number advances per marker attempt so a deferred marker still carries its own frame's number
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt   <= '0;
         marker_pend <= 1'b0;
      end else begin
         if (marker_req) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
         if (row_push) begin
            marker_pend <= marker_pend || frame_end;
         end else begin
            marker_pend <= marker_pend && frame_end;
         end
      end
   end
`else
   logic unused_frame_end;
   assign unused_frame_end = frame_end;
   assign push_req   = row_push;
   assign push_entry = {1'b0, ROW_W'(row_cnt), event_in_array};
`endif

   // No same-cycle pass-through: a push against a full FIFO is dropped even if it pops this cycle
   assign fifo_push = push_req && !fifo_full;

   evt_sync_fifo #(
      .WIDTH (ENT_W),
      .AW    (FIFO_AW)
   ) u_row_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Sticky drop indication and saturating drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (push_req && fifo_full) begin
         overflow <= 1'b1;
         if (drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

   assign work_marker = work_q[ENT_W-1];
   assign work_row    = work_q[EV_W +: ROW_W];
   assign work_ev     = work_q[EV_W-1:0];
   assign ev_shift    = work_ev >> {uid_q, 1'b0};
   assign cur_code    = ev_shift[1:0];

   assign busy = !fifo_empty || (state_q != IDLE);

   // Serialiser state, unit cursor and working entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         uid_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         uid_q   <= uid_d;
         work_q  <= work_d;
      end
   end

   // Next-state and stream outputs: scan units in ascending order, emit hi then lo byte per event
   always_comb begin
      state_d  = state_q;
      uid_d    = uid_q;
      work_d   = work_q;
      fifo_pop = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      rec      = work_marker ? make_record(EVT_NONE, MARKER_UID, work_row)
                             : make_record(cur_code, uid_q, work_row);
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               work_d   = fifo_rd;
               uid_d    = '0;
               state_d  = SCAN;
            end
         end
         SCAN: begin
            if (work_marker || (cur_code != EVT_NONE)) begin
               state_d = SEND_HI;
            end else if (uid_q == LAST_UID) begin
               state_d = IDLE;
            end else begin
               uid_d = uid_q + 1'b1;
            end
         end
         SEND_HI: begin
            tx_valid = 1'b1;
            tx_data  = rec[15:8];
            if (tx_ready) begin
               state_d = SEND_LO;
            end
         end
         SEND_LO: begin
            tx_valid = 1'b1;
            tx_data  = rec[7:0];
            if (tx_ready) begin
               if (work_marker || (uid_q == LAST_UID)) begin
                  state_d = IDLE;
               end else begin
                  uid_d   = uid_q + 1'b1;
                  state_d = SCAN;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_event_tx_packer.sv
// Self-checking bench for event_tx_packer: directed scenarios plus randomized rows against a byte-level model.
// Latency: checks first-byte timing of a unit-0 event.
// Backpressure: exercises held tx_ready, random tx_ready and FIFO overflow.
`timescale 1ns/1ps
module tb_event_tx_packer;

   localparam int N  = 4;
   localparam int AW = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [2*N-1:0] event_in_array = '0;
   logic           event_in_valid = 1'b0;
   logic           frame_start = 1'b0;
   logic           frame_end = 1'b0;
   logic           tx_ready = 1'b1;
   logic [7:0]     tx_data;
   logic           tx_valid;
   logic           overflow;
   logic [7:0]     drop_count;
   logic           busy;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         rx_cyc[$];
   int         cyc = 0;
   int         vld_cycles = 0;
   int         hold_viol = 0;
   bit         rnd_ready = 0;

   logic [AW-1:0] row_m = '0;
   logic [7:0]    frame_m = '0;

   logic       p_vld = 1'b0;
   logic       p_rdy = 1'b0;
   logic [7:0] p_dat = '0;

   event_tx_packer #(.NUM_UNITS(N), .ADDR_WIDTH(AW), .FIFO_AW(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .event_in_array (event_in_array),
      .event_in_valid (event_in_valid),
      .frame_start    (frame_start),
      .frame_end      (frame_end),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .overflow       (overflow),
      .drop_count     (drop_count),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Byte capture and stream-stability tracking on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         p_vld = 1'b0;
      end else begin
         if (p_vld && !p_rdy && (tx_valid !== 1'b1 || tx_data !== p_dat)) hold_viol++;
         if (tx_valid) vld_cycles++;
         if (tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            rx_cyc.push_back(cyc);
         end
         p_vld = tx_valid;
         p_rdy = tx_ready;
         p_dat = tx_data;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic clear_bufs();
      exp_q.delete();
      rx_q.delete();
      rx_cyc.delete();
      vld_cycles = 0;
      hold_viol  = 0;
   endtask

   // Reference model: one 2-byte record per nonzero unit code, ascending unit id, row = counter value
   task automatic model_row(input logic [2*N-1:0] ev, input bit keep);
      logic [1:0] code;
      if (keep) begin
         for (int u = 0; u < N; u++) begin
            code = ev[2*u +: 2];
            if (code != 2'b00) begin
               exp_q.push_back({code, 6'(u)});
               exp_q.push_back(8'(row_m));
            end
         end
      end
      row_m = row_m + 1'b1;
   endtask

   task automatic drive_row(input logic [2*N-1:0] ev, input bit keep);
      event_in_valid = 1'b1;
      event_in_array = ev;
      model_row(ev, keep);
      tick();
      event_in_valid = 1'b0;
      event_in_array = '0;
   endtask

   task automatic pulse_frame_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      row_m = '0;
   endtask

   task automatic wait_idle(input int maxc, output bit to);
      to = 1'b1;
      for (int i = 0; i < maxc; i++) begin
         if (!busy && !tx_valid) begin
            to = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %0b want 0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
      checks++; if (drop_count !== 8'h00) begin failures++; $display("FAIL reset_drop_count: got %h want 00", drop_count); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle: busy=%0b tx_valid=%0b want 0 0", busy, tx_valid); end
   endtask

   task automatic test_single_event();
      bit to;
      clear_bufs();
      tx_ready = 1'b1;
      pulse_frame_start();
      for (int i = 0; i < 3; i++) drive_row('0, 1);
      drive_row(8'b0000_0100, 1);
      wait_idle(200, to);
      checks++; if (to || rx_q.size() != 2) begin failures++; $display("FAIL single_count: timeout=%0b bytes=%0d want 2", to, rx_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      checks++; if (vld_cycles != 2) begin failures++; $display("FAIL single_valid_cycles: got %0d want 2", vld_cycles); end
   endtask

   task automatic test_multi_unit();
      bit to;
      int p;
      clear_bufs();
      tx_ready = 1'b1;
      pulse_frame_start();
      p = cyc;
      drive_row(8'b1100_0010, 1);
      wait_idle(200, to);
      checks++; if (to || rx_q.size() != exp_q.size()) begin failures++; $display("FAIL multi_count: timeout=%0b bytes=%0d want %0d", to, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL multi_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      if (rx_cyc.size() > 0) begin
         checks++; if (rx_cyc[0] - p != 3) begin failures++; $display("FAIL multi_latency: got %0d want 3", rx_cyc[0] - p); end
      end
   endtask

   task automatic test_backpressure();
      bit to;
      clear_bufs();
      tx_ready = 1'b0;
      pulse_frame_start();
      drive_row(8'b0000_0100, 1);
      for (int i = 0; i < 20 && !tx_valid; i++) tick();
      checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid: got %0b want 1", tx_valid); end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin failures++; $display("FAIL bp_hold%0d: valid=%0b data=%h want 1 41", i, tx_valid, tx_data); end
      end
      tx_ready = 1'b1;
      wait_idle(200, to);
      checks++; if (to || rx_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count: timeout=%0b bytes=%0d want %0d", to, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      checks++; if (hold_viol != 0) begin failures++; $display("FAIL bp_stability: violations=%0d want 0", hold_viol); end
   endtask

   task automatic test_overflow();
      bit to;
      clear_bufs();
      tx_ready = 1'b0;
      pulse_frame_start();
      drive_row(8'($urandom_range(1, 255)), 1);
      for (int i = 0; i < 20 && !tx_valid; i++) tick();
      checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL ovf_stall: tx_valid=%0b want 1", tx_valid); end
      for (int i = 0; i < 10; i++) drive_row(8'($urandom_range(1, 255)), i < 8);
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
      checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL ovf_drop_count: got %0d want 2", drop_count); end
      tx_ready = 1'b1;
      wait_idle(1000, to);
      checks++; if (to || rx_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_count: timeout=%0b bytes=%0d want %0d", to, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
   endtask

   task automatic test_row_wrap();
      bit to;
      clear_bufs();
      tx_ready = 1'b1;
      pulse_frame_start();
      for (int c = 0; c < 40; c++) begin
         if (c == 31 || c == 32) drive_row(8'($urandom_range(1, 255)), 1);
         else drive_row('0, 1);
      end
      wait_idle(400, to);
      checks++; if (to || rx_q.size() != exp_q.size()) begin failures++; $display("FAIL wrap_count: timeout=%0b bytes=%0d want %0d", to, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      if (rx_q.size() >= 2) begin
         checks++; if (rx_q[1] !== 8'h1F) begin failures++; $display("FAIL wrap_first_row: got %h want 1f", rx_q[1]); end
         checks++; if (rx_q[rx_q.size()-1] !== 8'h00) begin failures++; $display("FAIL wrap_last_row: got %h want 00", rx_q[rx_q.size()-1]); end
      end
   endtask

   task automatic test_random_bursts();
      bit to;
      logic [2*N-1:0] ev;
      clear_bufs();
      pulse_frame_start();
      rnd_ready = 1;
      for (int b = 0; b < 6; b++) begin
         // At most 8 nonempty rows per burst: FIFO depth plus the working register can never be exceeded
         for (int r = 0; r < 8; r++) begin
            ev = ($urandom_range(0, 9) < 3) ? '0 : 8'($urandom);
            drive_row(ev, 1);
            if ($urandom_range(0, 3) == 0) tick();
         end
         wait_idle(2000, to);
         checks++; if (to) begin failures++; $display("FAIL rand_drain%0d: timeout busy=%0b want 0", b, busy); end
      end
      rnd_ready = 0;
      tx_ready  = 1'b1;
      checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: bytes=%0d want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL rand_no_drops: drop_count=%0d want 2", drop_count); end
      checks++; if (hold_viol != 0) begin failures++; $display("FAIL rand_stability: violations=%0d want 0", hold_viol); end
   endtask

`ifdef EVT_TX_FRAME_MARKER_EN
   task automatic test_marker();
      bit to;
      clear_bufs();
      tx_ready = 1'b1;
      pulse_frame_start();
      frame_end = 1'b1;
      drive_row(8'($urandom_range(1, 255)), 1);
      frame_end = 1'b0;
      exp_q.push_back(8'h3F);
      exp_q.push_back(frame_m);
      frame_m = frame_m + 8'd1;
      wait_idle(300, to);
      pulse_frame_start();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      exp_q.push_back(8'h3F);
      exp_q.push_back(frame_m);
      frame_m = frame_m + 8'd1;
      wait_idle(300, to);
      checks++; if (to || rx_q.size() != exp_q.size()) begin failures++; $display("FAIL marker_count: timeout=%0b bytes=%0d want %0d", to, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL marker_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      if (rx_q.size() >= 2) begin
         checks++; if (rx_q[rx_q.size()-1] !== 8'h01) begin failures++; $display("FAIL marker_second_frame: got %h want 01", rx_q[rx_q.size()-1]); end
      end
   endtask
`endif

   task automatic test_reset_mid_packet();
      bit to;
      clear_bufs();
      tx_ready = 1'b0;
      pulse_frame_start();
      drive_row(8'b0000_0100, 1);
      drive_row(8'b0001_0000, 1);
      for (int i = 0; i < 20 && !tx_valid; i++) tick();
      checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL rstmid_stall: tx_valid=%0b want 1", tx_valid); end
      rst = 1'b1;
      #1;
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_tx_valid: got %0b want 0", tx_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
      checks++; if (drop_count !== 8'h00 || overflow !== 1'b0) begin failures++; $display("FAIL rstmid_flags: drop=%0d ovf=%0b want 0 0", drop_count, overflow); end
      tick();
      tick();
      rst = 1'b0;
      tx_ready = 1'b1;
      clear_bufs();
      row_m = '0;
      tick();
      tick();
      checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_discard: valid=%0b busy=%0b want 0 0", tx_valid, busy); end
      drive_row(8'b1000_0000, 1);
      wait_idle(200, to);
      checks++; if (to || rx_q.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_after_count: timeout=%0b bytes=%0d want %0d", to, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_after_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_multi_unit();
      test_backpressure();
      test_overflow();
      test_row_wrap();
      test_random_bursts();
`ifdef EVT_TX_FRAME_MARKER_EN
      test_marker();
`endif
      test_reset_mid_packet();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
